// File: rtl/mau_lsu_pkg.sv
// rtl/mau_lsu_pkg.sv - shared encodings, state type and legality helper for the memory access unit
package mau_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic {ST_IDLE, ST_BUS} state_t;

  // Size/sign encoding must be supported for the direction and the address naturally aligned.
  function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_LB:  ok = 1'b1;
      F3_LH:  ok = ~off[0];
      F3_LW:  ok = (off == 2'b00);
      F3_LBU: ok = ~is_store;
      F3_LHU: ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mau_load_format.sv
// rtl/mau_load_format.sv - byte-lane select and sign/zero extension of a loaded word
module mau_load_format
  import mau_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    result  = shifted;
    case (funct3)
      F3_LB:   result = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  result = {24'h0, shifted[7:0]};
      F3_LHU:  result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mau_lsu.sv
// rtl/mau_lsu.sv - single-outstanding load/store unit with stall, hazard and error reporting
module mau_lsu
  import mau_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        riscv_LOAD,
  input  logic        riscv_STORE,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr_toMAU,
  input  logic [31:0] data_toMAU,
  input  logic [4:0]  rd_addr,
  input  logic [4:0]  dec_rs1_addr,
  input  logic [4:0]  dec_rs2_addr,
  input  logic        dec_rs1en,
  input  logic        dec_rs2en,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mau_stall,
  output logic        MAU_data_conflict,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] data_toReg,
  output logic        misalign_err,
  output logic        bus_err,
  output logic [31:0] err_addr
);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        access, legal, accept, timeout;
  logic [31:0] st_wdata, fmt_data;
  logic [3:0]  st_wstrb;

  assign access  = riscv_LOAD | riscv_STORE;
  assign legal   = access_legal(riscv_STORE, funct3, addr_toMAU[1:0]);
  assign accept  = (state_q == ST_IDLE) & access & legal;
  assign timeout = (state_q == ST_BUS) & ~mem_ack & (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign mem_req = (state_q == ST_BUS);

  assign mau_stall = accept | ((state_q == ST_BUS) & ~mem_ack & ~timeout);

  function automatic logic dec_reads(input logic [4:0] r);
    return (dec_rs1en & (dec_rs1_addr == r)) | (dec_rs2en & (dec_rs2_addr == r));
  endfunction

  // The hazard covers the accept cycle, the bus wait and the writeback cycle of a load.
  assign MAU_data_conflict =
      (accept & ~riscv_STORE & (rd_addr != 5'd0) & dec_reads(rd_addr)) |
      ((state_q == ST_BUS) & ~mem_we & (rd_q != 5'd0) & dec_reads(rd_q)) |
      (wb_valid & (wb_rd != 5'd0) & dec_reads(wb_rd));

  always_comb begin
    st_wdata = data_toMAU;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{data_toMAU[7:0]}};
        st_wstrb = 4'b0001 << addr_toMAU[1:0];
      end
      2'b01: begin
        st_wdata = {2{data_toMAU[15:0]}};
        st_wstrb = 4'b0011 << addr_toMAU[1:0];
      end
      default: ;
    endcase
  end

  mau_load_format u_fmt (
    .rdata  (mem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .result (fmt_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUS;
      ST_BUS:  if (mem_ack || timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      mem_wstrb    <= 4'h0;
      cnt_q        <= 8'h0;
      f3_q         <= 3'h0;
      off_q        <= 2'h0;
      rd_q         <= 5'h0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'h0;
      data_toReg   <= 32'h0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      err_addr     <= 32'h0;
    end else begin
      wb_valid     <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (access && !legal) begin
          misalign_err <= 1'b1;
          err_addr     <= addr_toMAU;
        end else if (accept) begin
          mem_addr  <= {addr_toMAU[31:2], 2'b00};
          mem_we    <= riscv_STORE;
          mem_wdata <= riscv_STORE ? st_wdata : 32'h0;
          mem_wstrb <= riscv_STORE ? st_wstrb : 4'h0;
          f3_q      <= funct3;
          off_q     <= addr_toMAU[1:0];
          rd_q      <= rd_addr;
          cnt_q     <= 8'h0;
        end
      end else if (mem_ack) begin
        cnt_q <= 8'h0;
        if (!mem_we) begin
          wb_valid   <= 1'b1;
          wb_rd      <= rd_q;
          data_toReg <= fmt_data;
        end
      end else if (timeout) begin
        cnt_q    <= 8'h0;
        bus_err  <= 1'b1;
        err_addr <= {mem_addr[31:2], off_q};
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mau_lsu.sv
// tb/tb_mau_lsu.sv - directed self-checking bench for mau_lsu
module tb_mau_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        riscv_LOAD, riscv_STORE;
  logic [2:0]  funct3;
  logic [31:0] addr_toMAU, data_toMAU;
  logic [4:0]  rd_addr, dec_rs1_addr, dec_rs2_addr;
  logic        dec_rs1en, dec_rs2en;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mau_stall, MAU_data_conflict, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] data_toReg;
  logic        misalign_err, bus_err;
  logic [31:0] err_addr;

  int tests = 0;
  int fails = 0;

  logic        cap_req, cap_we, cap_wbv, cap_req_after;
  logic [31:0] cap_addr, cap_wdata, cap_data;
  logic [3:0]  cap_wstrb;
  logic [4:0]  cap_wbrd;
  int          cap_stall;

  always #5 clk = ~clk;

  mau_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .riscv_LOAD(riscv_LOAD), .riscv_STORE(riscv_STORE),
    .funct3(funct3), .addr_toMAU(addr_toMAU), .data_toMAU(data_toMAU), .rd_addr(rd_addr),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr), .dec_rs1en(dec_rs1en),
    .dec_rs2en(dec_rs2en), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mau_stall(mau_stall), .MAU_data_conflict(MAU_data_conflict), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .data_toReg(data_toReg), .misalign_err(misalign_err), .bus_err(bus_err),
    .err_addr(err_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one access, acks it after 'waits' idle bus cycles and captures what the bus and writeback showed.
  task automatic bus_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input logic [31:0] rdata, input int waits);
    step();
    riscv_LOAD = ld; riscv_STORE = st; funct3 = f3;
    addr_toMAU = addr; data_toMAU = data; rd_addr = rd;
    #1;
    cap_stall = mau_stall ? 1 : 0;
    step();
    riscv_LOAD = 1'b0; riscv_STORE = 1'b0;
    #1;
    cap_req = mem_req; cap_we = mem_we; cap_addr = mem_addr;
    cap_wdata = mem_wdata; cap_wstrb = mem_wstrb;
    for (int k = 0; k <= waits; k++) begin
      if (k == waits) begin
        mem_ack = 1'b1; mem_rdata = rdata;
        #1;
      end
      if (mau_stall) cap_stall++;
      if (k == waits) break;
      step();
    end
    step();
    mem_ack = 1'b0;
    #1;
    cap_wbv = wb_valid; cap_wbrd = wb_rd; cap_data = data_toReg; cap_req_after = mem_req;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    riscv_LOAD = 0; riscv_STORE = 0; funct3 = 0; addr_toMAU = 0; data_toMAU = 0; rd_addr = 0;
    dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rs1en = 0; dec_rs2en = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", mem_req); end
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", mem_we); end
    tests++; if (mem_wstrb !== 4'h0) begin fails++; $display("FAIL reset_wstrb: got %h want 0", mem_wstrb); end
    tests++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    tests++; if ({wb_valid, misalign_err, bus_err, mau_stall} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {wb_valid, misalign_err, bus_err, mau_stall}); end
    tests++; if ({data_toReg, err_addr} !== 64'h0) begin fails++; $display("FAIL reset_data: got %h want 0", {data_toReg, err_addr}); end
    reset = 1'b0;
  endtask

  task automatic test_stores();
    bus_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h0, 2);
    tests++; if ({cap_req, cap_we} !== 2'b11) begin fails++; $display("FAIL sw_req_we: got %b want 11", {cap_req, cap_we}); end
    tests++; if (cap_addr !== 32'h100) begin fails++; $display("FAIL sw_addr: got %h want 00000100", cap_addr); end
    tests++; if (cap_wstrb !== 4'b1111) begin fails++; $display("FAIL sw_wstrb: got %b want 1111", cap_wstrb); end
    tests++; if (cap_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_wdata: got %h want deadbeef", cap_wdata); end
    tests++; if (cap_stall != 3) begin fails++; $display("FAIL sw_stall_cycles: got %0d want 3", cap_stall); end
    tests++; if ({cap_wbv, cap_req_after} !== 2'b00) begin fails++; $display("FAIL sw_no_wb: got %b want 00", {cap_wbv, cap_req_after}); end

    bus_op(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd0, 32'h0, 0);
    tests++; if (cap_addr !== 32'h200) begin fails++; $display("FAIL sb_addr: got %h want 00000200", cap_addr); end
    tests++; if (cap_wstrb !== 4'b1000) begin fails++; $display("FAIL sb_wstrb: got %b want 1000", cap_wstrb); end
    tests++; if (cap_wdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL sb_wdata: got %h want a5a5a5a5", cap_wdata); end

    bus_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234BEEF, 5'd0, 32'h0, 1);
    tests++; if (cap_wstrb !== 4'b1100) begin fails++; $display("FAIL sh_wstrb: got %b want 1100", cap_wstrb); end
    tests++; if (cap_wdata !== 32'hBEEFBEEF) begin fails++; $display("FAIL sh_wdata: got %h want beefbeef", cap_wdata); end
  endtask

  task automatic test_loads();
    bus_op(1'b1, 1'b0, 3'b000, 32'h301, 32'h0, 5'd5, 32'h123480FF, 1);
    tests++; if ({cap_req, cap_we, cap_wstrb} !== 6'b10_0000) begin fails++; $display("FAIL lb_bus: got %b want 100000", {cap_req, cap_we, cap_wstrb}); end
    tests++; if (cap_addr !== 32'h300) begin fails++; $display("FAIL lb_addr: got %h want 00000300", cap_addr); end
    tests++; if ({cap_wbv, cap_wbrd} !== {1'b1, 5'd5}) begin fails++; $display("FAIL lb_wb: got %b/%0d want 1/5", cap_wbv, cap_wbrd); end
    tests++; if (cap_data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_data: got %h want ffffff80", cap_data); end
    step();
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL lb_wb_pulse: got %b want 0", wb_valid); end

    bus_op(1'b1, 1'b0, 3'b100, 32'h301, 32'h0, 5'd5, 32'h123480FF, 0);
    tests++; if (cap_data !== 32'h00000080) begin fails++; $display("FAIL lbu_data: got %h want 00000080", cap_data); end
    bus_op(1'b1, 1'b0, 3'b101, 32'h302, 32'h0, 5'd6, 32'h123480FF, 0);
    tests++; if (cap_data !== 32'h00001234) begin fails++; $display("FAIL lhu_data: got %h want 00001234", cap_data); end
    bus_op(1'b1, 1'b0, 3'b001, 32'h300, 32'h0, 5'd6, 32'h123480FF, 0);
    tests++; if (cap_data !== 32'hFFFF80FF) begin fails++; $display("FAIL lh_data: got %h want ffff80ff", cap_data); end
    bus_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd9, 32'h123480FF, 3);
    tests++; if ({cap_wbrd, cap_data} !== {5'd9, 32'h123480FF}) begin fails++; $display("FAIL lw_data: got %0d/%h want 9/123480ff", cap_wbrd, cap_data); end
  endtask

  task automatic test_misalign();
    step();
    riscv_LOAD = 1'b1; funct3 = 3'b010; addr_toMAU = 32'h102; rd_addr = 5'd4;
    #1;
    tests++; if (mau_stall !== 1'b0) begin fails++; $display("FAIL lw_mis_stall: got %b want 0", mau_stall); end
    step();
    riscv_LOAD = 1'b0;
    #1;
    tests++; if ({misalign_err, mem_req} !== 2'b10) begin fails++; $display("FAIL lw_mis_pulse: got %b want 10", {misalign_err, mem_req}); end
    tests++; if (err_addr !== 32'h102) begin fails++; $display("FAIL lw_mis_addr: got %h want 00000102", err_addr); end
    step();
    tests++; if ({misalign_err, mem_req} !== 2'b00) begin fails++; $display("FAIL lw_mis_after: got %b want 00", {misalign_err, mem_req}); end

    riscv_STORE = 1'b1; funct3 = 3'b100; addr_toMAU = 32'h204;
    step();
    riscv_STORE = 1'b0;
    #1;
    tests++; if ({misalign_err, mem_req, err_addr} !== {2'b10, 32'h204}) begin fails++; $display("FAIL st_f3_illegal: got %b/%h want 10/00000204", {misalign_err, mem_req}, err_addr); end
  endtask

  task automatic test_conflict();
    step();
    riscv_LOAD = 1'b1; funct3 = 3'b010; addr_toMAU = 32'h500; rd_addr = 5'd7;
    dec_rs1_addr = 5'd7; dec_rs1en = 1'b1;
    #1;
    tests++; if (MAU_data_conflict !== 1'b1) begin fails++; $display("FAIL conf_accept: got %b want 1", MAU_data_conflict); end
    step();
    riscv_LOAD = 1'b0; dec_rs1en = 1'b0; dec_rs2_addr = 5'd7; dec_rs2en = 1'b1;
    #1;
    tests++; if (MAU_data_conflict !== 1'b1) begin fails++; $display("FAIL conf_bus: got %b want 1", MAU_data_conflict); end
    dec_rs2en = 1'b0;
    #1;
    tests++; if (MAU_data_conflict !== 1'b0) begin fails++; $display("FAIL conf_bus_noen: got %b want 0", MAU_data_conflict); end
    dec_rs2en = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0;
    step();
    mem_ack = 1'b0;
    #1;
    tests++; if ({wb_valid, MAU_data_conflict} !== 2'b11) begin fails++; $display("FAIL conf_wb: got %b want 11", {wb_valid, MAU_data_conflict}); end
    dec_rs2en = 1'b0;

    step();
    riscv_LOAD = 1'b1; rd_addr = 5'd0; dec_rs1_addr = 5'd0; dec_rs1en = 1'b1;
    #1;
    tests++; if (MAU_data_conflict !== 1'b0) begin fails++; $display("FAIL conf_x0: got %b want 0", MAU_data_conflict); end
    step();
    riscv_LOAD = 1'b0;
    #1;
    tests++; if (MAU_data_conflict !== 1'b0) begin fails++; $display("FAIL conf_x0_bus: got %b want 0", MAU_data_conflict); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; dec_rs1_addr = 5'd7;
    step();
    riscv_STORE = 1'b1; rd_addr = 5'd7;
    #1;
    tests++; if ({mau_stall, MAU_data_conflict} !== 2'b10) begin fails++; $display("FAIL conf_store: got %b want 10", {mau_stall, MAU_data_conflict}); end
    step();
    riscv_STORE = 1'b0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; dec_rs1en = 1'b0;
  endtask

  task automatic test_back_to_back();
    step();
    riscv_STORE = 1'b1; funct3 = 3'b010; addr_toMAU = 32'h600; data_toMAU = 32'h1;
    step();
    riscv_STORE = 1'b0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; riscv_LOAD = 1'b1; addr_toMAU = 32'h604; rd_addr = 5'd2;
    #1;
    tests++; if ({mem_req, mau_stall} !== 2'b01) begin fails++; $display("FAIL b2b_accept: got %b want 01", {mem_req, mau_stall}); end
    step();
    riscv_LOAD = 1'b0;
    tests++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h604}) begin fails++; $display("FAIL b2b_bus: got %b/%h want 10/00000604", {mem_req, mem_we}, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_ack = 1'b0;
    tests++; if ({wb_valid, data_toReg} !== {1'b1, 32'hCAFEF00D}) begin fails++; $display("FAIL b2b_wb: got %b/%h want 1/cafef00d", wb_valid, data_toReg); end
  endtask

  task automatic test_ack_idle();
    step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    tests++; if ({wb_valid, mem_req, bus_err} !== 3'b000) begin fails++; $display("FAIL ack_idle: got %b want 000", {wb_valid, mem_req, bus_err}); end
  endtask

  task automatic test_timeout();
    int n;
    logic last_stall;
    step();
    riscv_LOAD = 1'b1; funct3 = 3'b010; addr_toMAU = 32'h400; rd_addr = 5'd3;
    step();
    riscv_LOAD = 1'b0;
    n = 0; last_stall = 1'b1;
    while (mem_req && n < 20) begin
      n++;
      last_stall = mau_stall;
      step();
    end
    tests++; if (n != 4) begin fails++; $display("FAIL tmo_cycles: got %0d want 4", n); end
    tests++; if (last_stall !== 1'b0) begin fails++; $display("FAIL tmo_stall: got %b want 0", last_stall); end
    tests++; if ({bus_err, wb_valid, err_addr} !== {2'b10, 32'h400}) begin fails++; $display("FAIL tmo_err: got %b/%h want 10/00000400", {bus_err, wb_valid}, err_addr); end
    step();
    tests++; if ({bus_err, wb_valid, mem_req} !== 3'b000) begin fails++; $display("FAIL tmo_after: got %b want 000", {bus_err, wb_valid, mem_req}); end
  endtask

  task automatic test_reset_mid_bus();
    step();
    riscv_LOAD = 1'b1; funct3 = 3'b010; addr_toMAU = 32'h700; rd_addr = 5'd8;
    step();
    riscv_LOAD = 1'b0;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_bus_pre: got %b want 1", mem_req); end
    reset = 1'b1;
    #1;
    tests++; if ({mem_req, mau_stall, mem_addr} !== {2'b00, 32'h0}) begin fails++; $display("FAIL rst_bus_async: got %b/%h want 00/00000000", {mem_req, mau_stall}, mem_addr); end
    step();
    reset = 1'b0;
    step();
    tests++; if ({wb_valid, bus_err, misalign_err, mem_req} !== 4'b0000) begin fails++; $display("FAIL rst_bus_nopulse: got %b want 0000", {wb_valid, bus_err, misalign_err, mem_req}); end
  endtask

  initial begin
    test_reset();
    test_stores();
    test_loads();
    test_misalign();
    test_conflict();
    test_back_to_back();
    test_ack_idle();
    test_timeout();
    test_reset_mid_bus();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
